// File: rtl/bch_correct_buffer.sv
// Receive-side BCH correction buffer: stores the data beats of one codeword,
// XORs the Chien-search error masks into them, then drains the corrected words.
module bch_correct_buffer #(
   parameter int BITS       = 8,
   parameter int DATA_WORDS = 4,
   parameter int ECC_WORDS  = 2
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [BITS-1:0] in_data,
   input  logic            in_first,
   input  logic            in_last,
   input  logic            err_valid,
   input  logic [BITS-1:0] err,
   input  logic            err_first,
   input  logic            err_last,
   input  logic            no_err,
   input  logic            dec_fail,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [BITS-1:0] out_data,
   output logic            out_first,
   output logic            out_last,
   output logic            out_fail,
   output logic            busy
);

   localparam int TOTAL = DATA_WORDS + ECC_WORDS;
   localparam int CW    = $clog2(TOTAL + 2);
   localparam int IW    = (DATA_WORDS > 1) ? $clog2(DATA_WORDS) : 1;

   localparam logic [CW-1:0] TOTAL_C = CW'(TOTAL);
   localparam logic [CW-1:0] OVER_C  = CW'(TOTAL + 1);
   localparam logic [CW-1:0] DW_C    = CW'(DATA_WORDS);
   localparam logic [CW-1:0] LAST_C  = CW'(DATA_WORDS - 1);

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      WAIT_ERR,
      CORRECT,
      DRAIN
   } state_t;

   state_t          state, state_n;
   logic [BITS-1:0] mem [DATA_WORDS];
   logic [CW-1:0]   cnt, cnt_n;
   logic [CW-1:0]   widx, widx_n;
   logic [CW-1:0]   ridx, ridx_n;
   logic            fail, fail_n;
   logic            we;
   logic [IW-1:0]   wa;
   logic [BITS-1:0] wd;
   logic [CW-1:0]   beats;
   logic            accept;

   assign in_ready = (state == IDLE) || (state == LOAD);
   assign busy     = (state != IDLE);
   assign accept   = in_valid && in_ready;

   // Beat count including the one being accepted; in_first restarts at 1.
   assign beats = in_first ? CW'(1) : ((cnt == OVER_C) ? cnt : cnt + CW'(1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_n;
   end

   always_comb begin
      state_n   = state;
      cnt_n     = cnt;
      widx_n    = widx;
      ridx_n    = ridx;
      fail_n    = fail;
      we        = 1'b0;
      wa        = '0;
      wd        = in_data;
      out_valid = 1'b0;
      out_data  = '0;
      out_first = 1'b0;
      out_last  = 1'b0;
      out_fail  = 1'b0;

      case (state)
         IDLE, LOAD: begin
            if (accept && (in_first || state == LOAD)) begin
               cnt_n = beats;
               if (in_first) begin
                  we = 1'b1;
                  wa = '0;
               end else if (cnt < DW_C) begin
                  we = 1'b1;
                  wa = cnt[IW-1:0];
               end
               if (in_last) begin
                  if (beats == TOTAL_C) begin
                     state_n = WAIT_ERR;
                  end else begin
                     fail_n  = 1'b1;
                     state_n = DRAIN;
                  end
               end else if (beats == OVER_C) begin
                  fail_n  = 1'b1;
                  state_n = DRAIN;
               end else begin
                  state_n = LOAD;
               end
            end
         end
         WAIT_ERR: begin
            if (dec_fail) begin
               fail_n  = 1'b1;
               state_n = DRAIN;
            end else if (no_err) begin
               state_n = DRAIN;
            end else if (err_valid && err_first) begin
               we     = 1'b1;
               wa     = '0;
               wd     = mem[0] ^ err;
               widx_n = CW'(1);
               state_n = (err_last || DATA_WORDS == 1) ? DRAIN : CORRECT;
            end
         end
         CORRECT: begin
            // A decode failure keeps whatever XORs were already applied.
            if (dec_fail) begin
               fail_n  = 1'b1;
               state_n = DRAIN;
            end else if (err_valid) begin
               we     = 1'b1;
               wa     = widx[IW-1:0];
               wd     = mem[widx[IW-1:0]] ^ err;
               widx_n = widx + CW'(1);
               if (err_last || widx == LAST_C) state_n = DRAIN;
            end
         end
         DRAIN: begin
            out_valid = 1'b1;
            out_data  = mem[ridx[IW-1:0]];
            out_first = (ridx == '0);
            out_last  = (ridx == LAST_C);
            out_fail  = fail;
            if (out_ready) begin
               if (ridx == LAST_C) begin
                  state_n = IDLE;
                  fail_n  = 1'b0;
                  ridx_n  = '0;
                  cnt_n   = '0;
                  widx_n  = '0;
               end else begin
                  ridx_n = ridx + CW'(1);
               end
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt  <= '0;
         widx <= '0;
         ridx <= '0;
         fail <= 1'b0;
         for (int i = 0; i < DATA_WORDS; i++) mem[i] <= '0;
      end else begin
         cnt  <= cnt_n;
         widx <= widx_n;
         ridx <= ridx_n;
         fail <= fail_n;
         if (we) mem[wa] <= wd;
      end
   end

endmodule

// File: tb/tb_bch_correct_buffer.sv
// Directed bench for bch_correct_buffer: a transaction-level model predicts the
// drained words, and a negedge monitor compares the DUT against it every cycle.
module tb_bch_correct_buffer;

   localparam int BITS  = 8;
   localparam int DW    = 4;
   localparam int EW    = 2;
   localparam int TOTAL = DW + EW;

   logic            clk       = 1'b0;
   logic            rst_n     = 1'b1;
   logic            in_valid  = 1'b0;
   logic            in_ready;
   logic [BITS-1:0] in_data   = '0;
   logic            in_first  = 1'b0;
   logic            in_last   = 1'b0;
   logic            err_valid = 1'b0;
   logic [BITS-1:0] err       = '0;
   logic            err_first = 1'b0;
   logic            err_last  = 1'b0;
   logic            no_err    = 1'b0;
   logic            dec_fail  = 1'b0;
   logic            out_valid;
   logic            out_ready = 1'b1;
   logic [BITS-1:0] out_data;
   logic            out_first;
   logic            out_last;
   logic            out_fail;
   logic            busy;

   bch_correct_buffer #(.BITS(BITS), .DATA_WORDS(DW), .ECC_WORDS(EW)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .in_first(in_first), .in_last(in_last),
      .err_valid(err_valid), .err(err), .err_first(err_first), .err_last(err_last),
      .no_err(no_err), .dec_fail(dec_fail),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_first(out_first), .out_last(out_last), .out_fail(out_fail),
      .busy(busy)
   );

   always #5 clk = ~clk;

   typedef enum {M_IDLE, M_LOAD, M_WAIT, M_CORR, M_DRAIN} mphase_t;
   typedef struct packed {
      logic [BITS-1:0] d;
      logic            f;
      logic            l;
      logic            fl;
   } beat_t;

   beat_t           sb[$];
   logic [BITS-1:0] m_mem [DW];
   int              m_cnt;
   int              m_widx;
   mphase_t         m_phase = M_IDLE;
   logic [BITS-1:0] frame_q[$];
   logic [BITS-1:0] errq[$];
   int              n_total = 0;
   int              n_pass  = 0;
   bit              exp_valid;
   beat_t           exp_b;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic failTimeout(input string name);
      n_total++;
      $display("[TB] FAIL %s: got timeout expected progress", name);
   endtask

   function automatic void modelReset();
      for (int i = 0; i < DW; i++) m_mem[i] = '0;
      sb.delete();
      m_cnt   = 0;
      m_widx  = 0;
      m_phase = M_IDLE;
   endfunction

   // The drained frame is always the whole DW-word buffer, flagged if failed.
   function automatic void modelFinish(input bit f);
      for (int i = 0; i < DW; i++) sb.push_back({m_mem[i], i == 0, i == DW - 1, f});
      m_phase = M_DRAIN;
   endfunction

   function automatic void modelBeat(input logic [BITS-1:0] d, input bit first, input bit last);
      if (m_phase != M_IDLE && m_phase != M_LOAD) return;
      if (m_phase == M_IDLE && !first) return;
      if (first) m_cnt = 0;
      if (m_cnt < DW) m_mem[m_cnt] = d;
      if (m_cnt < TOTAL + 1) m_cnt++;
      if (last) begin
         if (m_cnt == TOTAL) m_phase = M_WAIT;
         else modelFinish(1'b1);
      end else if (m_cnt == TOTAL + 1) modelFinish(1'b1);
      else m_phase = M_LOAD;
   endfunction

   function automatic void modelErr(input logic [BITS-1:0] e, input bit first, input bit last);
      if (m_phase == M_WAIT && first) begin
         m_mem[0] ^= e;
         m_widx = 1;
         if (last || DW == 1) modelFinish(1'b0);
         else m_phase = M_CORR;
      end else if (m_phase == M_CORR) begin
         m_mem[m_widx] ^= e;
         m_widx++;
         if (last || m_widx == DW) modelFinish(1'b0);
      end
   endfunction

   task automatic sendBeat(input logic [BITS-1:0] d, input bit first, input bit last);
      bit ok = 1'b0;
      in_valid = 1'b1;
      in_data  = d;
      in_first = first;
      in_last  = last;
      for (int c = 0; c < 50 && !ok; c++) begin
         @(negedge clk);
         ok = in_ready;
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      in_first = 1'b0;
      in_last  = 1'b0;
      if (!ok) failTimeout("in_accept");
      else modelBeat(d, first, last);
   endtask

   task automatic applyStimulus(input bit with_last);
      for (int i = 0; i < frame_q.size(); i++)
         sendBeat(frame_q[i], i == 0, with_last && (i == frame_q.size() - 1));
   endtask

   task automatic sendErrs(input bit with_last);
      for (int i = 0; i < errq.size(); i++) begin
         err_valid = 1'b1;
         err       = errq[i];
         err_first = (i == 0);
         err_last  = with_last && (i == errq.size() - 1);
         @(posedge clk);
         #1;
         modelErr(errq[i], i == 0, with_last && (i == errq.size() - 1));
      end
      err_valid = 1'b0;
      err_first = 1'b0;
      err_last  = 1'b0;
   endtask

   task automatic pulse(input bit is_fail);
      if (is_fail) dec_fail = 1'b1;
      else         no_err   = 1'b1;
      @(posedge clk);
      #1;
      dec_fail = 1'b0;
      no_err   = 1'b0;
      if (m_phase == M_WAIT || (is_fail && m_phase == M_CORR)) modelFinish(is_fail);
   endtask

   task automatic waitIdle(input bit toggle);
      for (int c = 0; c < 200; c++) begin
         if (m_phase == M_IDLE) break;
         @(posedge clk);
         #1;
         out_ready = toggle ? ~out_ready : 1'b1;
      end
      if (m_phase != M_IDLE) failTimeout("drain");
      else begin
         checkOutput("idle_busy", busy, 0);
         checkOutput("idle_in_ready", in_ready, 1);
      end
      out_ready = 1'b1;
   endtask

   task automatic checkResetOutputs(input string tag);
      checkOutput({tag, "_out_valid"}, out_valid, 0);
      checkOutput({tag, "_out_data"}, out_data, 0);
      checkOutput({tag, "_out_first"}, out_first, 0);
      checkOutput({tag, "_out_last"}, out_last, 0);
      checkOutput({tag, "_out_fail"}, out_fail, 0);
      checkOutput({tag, "_busy"}, busy, 0);
      checkOutput({tag, "_in_ready"}, in_ready, 1);
   endtask

   // Per-cycle compare; the front beat must persist until out_ready takes it.
   always @(negedge clk) begin
      if (rst_n) begin
         exp_valid = (m_phase == M_DRAIN) && (sb.size() > 0);
         checkOutput("out_valid", out_valid, exp_valid);
         if (exp_valid) begin
            exp_b = sb[0];
            checkOutput("out_data", out_data, exp_b.d);
            checkOutput("out_first", out_first, exp_b.f);
            checkOutput("out_last", out_last, exp_b.l);
            checkOutput("out_fail", out_fail, exp_b.fl);
            checkOutput("drain_in_ready", in_ready, 0);
            checkOutput("drain_busy", busy, 1);
            if (out_ready) begin
               sb.delete(0);
               if (sb.size() == 0) m_phase = M_IDLE;
            end
         end
      end
   end

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: got no finish expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      modelReset();
      #1 rst_n = 1'b0;
      #2 checkResetOutputs("reset");
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Clean frame, no_err: first beat one cycle after the pulse.
      frame_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'hE0, 8'hE1};
      applyStimulus(1'b1);
      checkOutput("wait_busy", busy, 1);
      checkOutput("wait_in_ready", in_ready, 0);
      pulse(1'b0);
      checkOutput("noerr_lat_valid", out_valid, 1);
      checkOutput("noerr_lat_data", out_data, 8'h11);
      checkOutput("noerr_lat_first", out_first, 1);
      waitIdle(1'b0);

      // Corrected frame drained with out_ready toggling.
      out_ready = 1'b0;
      applyStimulus(1'b1);
      errq = '{8'h00, 8'h04, 8'h00, 8'h80};
      sendErrs(1'b1);
      checkOutput("model_w1", sb[1].d, 8'h26);
      checkOutput("model_w3", sb[3].d, 8'hC4);
      waitIdle(1'b1);

      // dec_fail, then error beats during drain and in idle must be ignored.
      out_ready = 1'b0;
      applyStimulus(1'b1);
      pulse(1'b1);
      errq = '{8'hFF, 8'hFF, 8'hFF, 8'hFF};
      sendErrs(1'b1);
      waitIdle(1'b0);
      sendErrs(1'b1);
      pulse(1'b0);
      checkOutput("idle_ignore_busy", busy, 0);

      // dec_fail after a partial correction keeps the partial XOR.
      applyStimulus(1'b1);
      errq = '{8'h01};
      sendErrs(1'b0);
      pulse(1'b1);
      checkOutput("model_partial_w0", sb[0].d, 8'h10);
      waitIdle(1'b0);

      // Error stream without err_last ends after DATA_WORDS beats.
      applyStimulus(1'b1);
      errq = '{8'h01, 8'h02, 8'h03, 8'h04};
      sendErrs(1'b0);
      checkOutput("model_full_w3", sb[3].d, 8'h40);
      waitIdle(1'b0);

      // Short frame: straight to drain with fail.
      frame_q = '{8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5};
      applyStimulus(1'b1);
      checkOutput("short_valid", out_valid, 1);
      checkOutput("short_fail", out_fail, 1);
      waitIdle(1'b0);

      // Overlong frame: fail on beat TOTAL+1.
      frame_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07};
      applyStimulus(1'b0);
      checkOutput("long_valid", out_valid, 1);
      checkOutput("long_fail", out_fail, 1);
      waitIdle(1'b0);

      // Two-beat frame leaves words 2..3 stale from the previous frame.
      frame_q = '{8'hB1, 8'hB2};
      applyStimulus(1'b1);
      checkOutput("model_stale_w2", sb[2].d, 8'h03);
      waitIdle(1'b0);

      // in_first mid-frame restarts the frame.
      sendBeat(8'hC1, 1'b1, 1'b0);
      sendBeat(8'hC2, 1'b0, 1'b0);
      frame_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'hE0, 8'hE1};
      applyStimulus(1'b1);
      checkOutput("restart_wait_busy", busy, 1);
      pulse(1'b0);
      waitIdle(1'b0);

      // Reset mid-correction, then a normal corrected frame.
      applyStimulus(1'b1);
      errq = '{8'h00, 8'h04};
      sendErrs(1'b0);
      #2 rst_n = 1'b0;
      modelReset();
      #1 checkResetOutputs("midreset");
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      applyStimulus(1'b1);
      errq = '{8'h00, 8'h04, 8'h00, 8'h80};
      sendErrs(1'b1);
      waitIdle(1'b1);

      repeat (2) @(posedge clk);
      #1;
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
